relm_fp_pack: RTL and testbench



---
 rtl/relm_fp_pack.sv | 162 ++++++++++++++++
 tb/tb_relm_fp_pack.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relm_fp_pack.sv
// Normalise / round-to-nearest-even / pack stage for the FP unit's intermediate result.
// Three-step sequencer (NORM, ROUND, DONE) with valid/ready on both sides.
module relm_fp_pack #(
    parameter int WD       = 32,
    parameter int BIAS_POS = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WD-1:0] in_flags,
    input  logic [WD-1:0] in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WD-1:0] out_float,
    output logic [2:0]    out_flags
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic                inf_q, inf_d;
    logic                zero_q, zero_d;
    logic [7:0]          exp_q, exp_d;
    logic [WD-1:0]       mant_q, mant_d;
    logic [WD-1:0]       norm_q, norm_d;
    logic signed [9:0]   e_q, e_d;
    logic                mzero_q, mzero_d;
    logic                out_valid_q, out_valid_d;
    logic [WD-1:0]       out_float_q, out_float_d;
    logic [2:0]          out_flags_q, out_flags_d;

    logic                accept;
    logic [4:0]          lead_pos;
    logic                round_up;
    logic [23:0]         frac_sum;
    logic signed [9:0]   e_fin;
    logic [WD-1:0]       res_float;
    logic [2:0]          res_flags;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_float = out_float_q;
    assign out_flags = out_flags_q;

    // Low flag bits carry nothing for this stage; the top mantissa bit is the
    // implicit leading one after normalisation.
    logic unused_bits;
    assign unused_bits = ^{in_flags[20:0], norm_q[31]};

    always_comb begin
        lead_pos = 5'd0;
        for (int i = 0; i < WD; i++) begin
            if (mant_q[i]) begin
                lead_pos = i[4:0];
            end
        end
    end

    always_comb begin
        round_up = norm_q[7] & ((|norm_q[6:0]) | norm_q[8]);
        frac_sum = {1'b0, norm_q[30:8]} + {23'd0, round_up};
        e_fin    = e_q + 10'(frac_sum[23]);

        res_float = {sign_q, e_fin[7:0], frac_sum[22:0]};
        res_flags = 3'b000;
        // Overflow sees the post-carry exponent; underflow uses the pre-round one.
        if (inf_q & zero_q) begin
            res_float = 32'h7FC0_0000;
            res_flags = 3'b100;
        end else if (inf_q | (e_fin >= 10'sd255)) begin
            res_float = {sign_q, 8'hFF, 23'd0};
            res_flags = 3'b010;
        end else if (zero_q | mzero_q | (e_q <= 10'sd0)) begin
            res_float = {sign_q, 31'd0};
            res_flags = 3'b001;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        inf_d       = inf_q;
        zero_d      = zero_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        norm_d      = norm_q;
        e_d         = e_q;
        mzero_d     = mzero_q;
        out_valid_d = out_valid_q;
        out_float_d = out_float_q;
        out_flags_d = out_flags_q;

        if (accept) begin
            sign_d = in_flags[31];
            exp_d  = in_flags[30:23];
            inf_d  = in_flags[22];
            zero_d = in_flags[21];
            mant_d = in_mant;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                norm_d  = mant_q << (5'd31 - lead_pos);
                e_d     = {2'b00, exp_q} + {5'd0, lead_pos} - 10'(BIAS_POS);
                mzero_d = (mant_q == '0);
                state_d = ROUND;
            end
            ROUND: begin
                out_float_d = res_float;
                out_flags_d = res_flags;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = accept ? NORM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            norm_q      <= '0;
            e_q         <= '0;
            mzero_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_float_q <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            inf_q       <= inf_d;
            zero_q      <= zero_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            norm_q      <= norm_d;
            e_q         <= e_d;
            mzero_q     <= mzero_d;
            out_valid_q <= out_valid_d;
            out_float_q <= out_float_d;
            out_flags_q <= out_flags_d;
        end
    end

endmodule

// File: tb/tb_relm_fp_pack.sv
// Bench for relm_fp_pack: arithmetic reference model plus scoreboard, directed vectors,
// latency, backpressure and asynchronous-reset scenarios.
module tb_relm_fp_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_flags;
    logic [31:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] f;
        logic [2:0]  fl;
    } exp_t;

    exp_t exp_q[$];

    localparam int NV = 19;
    localparam logic [31:0] TF [NV] = '{
        32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
        32'h3F80_0000, 32'h7F00_0000, 32'hFF00_0000, 32'h0080_0000, 32'h0060_0000,
        32'h8060_0000, 32'h7E80_0000, 32'h7F00_0000, 32'h0080_0000, 32'h3FA0_0000,
        32'hBF80_0000, 32'h3F8A_BCDE, 32'h8040_0000, 32'hC000_0000};
    localparam logic [31:0] TM [NV] = '{
        32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h4000_0040, 32'h4000_00C0,
        32'h7FFF_FFC0, 32'h8000_0000, 32'h8000_0000, 32'h2000_0000, 32'h1234_5678,
        32'h0000_0000, 32'h7FFF_FFC0, 32'h7FFF_FFC0, 32'h3FFF_FFE0, 32'h4000_0000,
        32'h0000_0000, 32'h4000_0000, 32'h0000_0001, 32'h6000_0000};
    localparam logic [31:0] TE [NV] = '{
        32'h3F80_0000, 32'h4000_0000, 32'h3080_0000, 32'h3F80_0000, 32'h3F80_0002,
        32'h4000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000,
        32'h7FC0_0000, 32'h7F00_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000,
        32'h8000_0000, 32'h3F80_0000, 32'hFF80_0000, 32'hC040_0000};
    localparam logic [2:0] TL [NV] = '{
        3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
        3'b000, 3'b010, 3'b010, 3'b001, 3'b100,
        3'b100, 3'b000, 3'b010, 3'b001, 3'b001,
        3'b001, 3'b000, 3'b010, 3'b000};

    relm_fp_pack #(.WD(32), .BIAS_POS(30)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flags  (in_flags),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact significand rounding by remainder comparison against one half ulp.
    function automatic exp_t model(input logic [31:0] fl, input logic [31:0] mant);
        exp_t            r;
        int              p;
        int              e0;
        int              e;
        longint unsigned m;
        longint unsigned sig;
        longint unsigned rem;
        p = 0;
        for (int i = 0; i < 32; i++) begin
            if (mant[i]) p = i;
        end
        e0  = int'(fl[30:23]) + p - 30;
        e   = e0;
        sig = 0;
        if (mant != 0) begin
            m   = ({32'd0, mant} << (31 - p)) & 64'hFFFF_FFFF;
            sig = m >> 8;
            rem = m & 64'd255;
            if (rem > 128 || (rem == 128 && sig[0])) sig = sig + 1;
            if (sig == (64'd1 << 24)) begin
                sig = 64'd1 << 23;
                e   = e + 1;
            end
        end
        if (fl[22] && fl[21]) begin
            r.f  = 32'h7FC0_0000;
            r.fl = 3'b100;
        end else if (fl[22] || e >= 255) begin
            r.f  = {fl[31], 8'hFF, 23'd0};
            r.fl = 3'b010;
        end else if (fl[21] || mant == 0 || e0 <= 0) begin
            r.f  = {fl[31], 31'd0};
            r.fl = 3'b001;
        end else begin
            r.f  = {fl[31], e[7:0], sig[22:0]};
            r.fl = 3'b000;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    // Scoreboard: every cycle with a valid output is compared, including held cycles.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out act=%h req=none", out_float);
            end else begin
                chk("out_float", out_float, exp_q[0].f);
                chk("out_flags", {29'd0, out_flags}, {29'd0, exp_q[0].fl});
                if (out_ready) begin
                    $display("retire float=%h flags=%b", out_float, out_flags);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] fl, input logic [31:0] m);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_flags = fl;
        in_mant  = m;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout act=no_accept req=accept");
        end else begin
            exp_q.push_back(model(fl, m));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_flags = 32'hFFFF_FFFF;
        in_mant  = 32'hA5A5_A5A5;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout act=%0d req=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t r;
        bit   seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_flags  = '0;
        in_mant   = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_float", out_float, 32'd0);
        chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency and ready profile for 1.0
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_flags = 32'h3F80_0000;
        in_mant  = 32'h4000_0000;
        @(negedge clk);
        chk("lat_in_ready_idle", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(model(32'h3F80_0000, 32'h4000_0000));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_flags = 32'hFFFF_FFFF;
        in_mant  = 32'h0000_0000;
        @(negedge clk);
        chk("lat_norm_in_ready", {31'd0, in_ready}, 32'd0);
        chk("lat_norm_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_round_in_ready", {31'd0, in_ready}, 32'd0);
        chk("lat_round_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_done_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_done_out_float", out_float, 32'h3F80_0000);
        chk("lat_done_out_flags", {29'd0, out_flags}, 32'd0);
        drain();

        // Pin the model to hand-computed values, then stream the vectors through the DUT
        for (int i = 0; i < NV; i++) begin
            r = model(TF[i], TM[i]);
            chk("model_float", r.f, TE[i]);
            chk("model_flags", {29'd0, r.fl}, {29'd0, TL[i]});
        end
        for (int i = 0; i < NV; i++) begin
            send(TF[i], TM[i]);
        end
        drain();

        // Backpressure: hold result, then retire and accept in the same edge
        out_ready = 1'b0;
        send(32'h3F80_0000, 32'h8000_0000);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("bp_out_valid_seen", {31'd0, seen}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_float", out_float, 32'h4000_0000);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_flags  = 32'h3F80_0000;
        in_mant   = 32'h4000_00C0;
        @(negedge clk);
        chk("bp_overlap_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(model(32'h3F80_0000, 32'h4000_00C0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mant  = 32'h0;
        @(negedge clk);
        chk("bp_next_norm_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("bp_next_round_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("bp_next_done_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_float", out_float, 32'h3F80_0002);
        drain();

        // Asynchronous reset during ROUND aborts the operation
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_flags = 32'h7F00_0000;
        in_mant  = 32'h8000_0000;
        @(negedge clk);
        chk("rst_test_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_float", out_float, 32'd0);
        chk("arst_out_flags", {29'd0, out_flags}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_no_residue", {31'd0, out_valid}, 32'd0);
        send(32'hC000_0000, 32'h6000_0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
